fc_vector_stream_tx: RTL and testbench

Transmit side of the valid/ready word stream that the fc_* layers consume on input_valid/input_ready/input_data.
- A producer (host loader or previous layer's output) writes whole x-vectors of N words into a ping-pong buffer.
- The block replays each vector to the fc layer one word per beat, with output_last marking word N-1.
- Decouples the producer from fc stalls; keeps one vector loading while the other is being sent.

---
 rtl/fc_stream_pkg.sv | 7 +
 rtl/fc_tx_bank_ram.sv | 19 +
 rtl/fc_vector_stream_tx.sv | 141 ++++++++++++++
 tb/tb_fc_vector_stream_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_stream_pkg.sv
// Shared types and default geometry for the fc_* stream layers.
package fc_stream_pkg;
   localparam int FC_WIDTH = 16;
   localparam int FC_N     = 8;

   typedef enum logic [1:0] {IDLE, FETCH, SEND} tx_state_t;
endpackage

// File: rtl/fc_tx_bank_ram.sv
// Two-bank vector store addressed as {bank, word}; one write port, registered read (1 cycle).
module fc_tx_bank_ram #(
   parameter int WIDTH = 16,
   parameter int LOGN  = 3
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [LOGN:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic [LOGN:0]    rd_addr,
   output logic [WIDTH-1:0] rd_dat
);
   logic [WIDTH-1:0] mem_q [2**(LOGN+1)];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_dat;
      rd_dat <= mem_q[rd_addr];
   end
endmodule

// File: rtl/fc_vector_stream_tx.sv
// Ping-pong vector buffer replaying N-word vectors to an fc layer at 1 word/cycle; first word 2 cycles
// after a bank fills, one bubble between back-to-back vectors; producer stalls only when both banks are full.
module fc_vector_stream_tx
   import fc_stream_pkg::*;
#(
   parameter int WIDTH = FC_WIDTH,
   parameter int N     = FC_N,
   parameter int LOGN  = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             output_valid,
   input  logic             output_ready,
   output logic [WIDTH-1:0] output_data,
   output logic             output_last,
   output logic [1:0]       vec_pending
);
   localparam logic [LOGN-1:0] LAST_WORD = LOGN'(N - 1);

   tx_state_t        state_q, state_d;
   logic             wbank_q, wbank_d;
   logic             rbank_q, rbank_d;
   logic [LOGN-1:0]  waddr_q, waddr_d;
   logic [LOGN-1:0]  raddr_q, raddr_d;
   logic [1:0]       full_q, full_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   logic             wr_fire, out_fire;
   logic             rd_bank;
   logic [LOGN-1:0]  rd_word, raddr_inc;
   logic [WIDTH-1:0] rd_dat;

   assign in_ready     = ~full_q[wbank_q];
   assign wr_fire      = in_valid & in_ready;
   assign out_fire     = out_valid_q & output_ready;
   assign raddr_inc    = raddr_q + LOGN'(1);
   assign output_valid = out_valid_q;
   assign output_last  = out_last_q;
   assign output_data  = out_data_q;
   assign vec_pending  = {1'b0, full_q[0]} + {1'b0, full_q[1]};

   fc_tx_bank_ram #(.WIDTH(WIDTH), .LOGN(LOGN)) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr ({wbank_q, waddr_q}),
      .wr_dat  (in_data),
      .rd_addr ({rd_bank, rd_word}),
      .rd_dat  (rd_dat)
   );

   always_comb begin
      state_d     = state_q;
      wbank_d     = wbank_q;
      rbank_d     = rbank_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      full_d      = full_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      rd_bank     = rbank_q;
      rd_word     = '0;

      if (wr_fire) begin
         if (waddr_q == LAST_WORD) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
            waddr_d         = '0;
         end else begin
            waddr_d = waddr_q + LOGN'(1);
         end
      end

      // The RAM address runs one word ahead of output_data so a fire can load the next word immediately.
      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (full_q[rbank_q]) state_d = FETCH;
         end
         FETCH: begin
            rd_word     = LOGN'(1);
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_data_d  = rd_dat;
            state_d     = SEND;
         end
         SEND: begin
            rd_word = (raddr_q == LAST_WORD) ? '0 : raddr_inc;
            if (out_fire) begin
               if (raddr_q != LAST_WORD) begin
                  raddr_d    = raddr_inc;
                  out_data_d = rd_dat;
                  out_last_d = (raddr_inc == LAST_WORD);
                  rd_word    = (raddr_inc == LAST_WORD) ? '0 : raddr_inc + LOGN'(1);
               end else begin
                  full_d[rbank_q] = 1'b0;
                  rbank_d         = ~rbank_q;
                  raddr_d         = '0;
                  out_valid_d     = 1'b0;
                  out_last_d      = 1'b0;
                  rd_bank         = ~rbank_q;
                  rd_word         = '0;
                  // A bank completing on this same edge counts, so it follows after a single bubble.
                  state_d         = full_d[~rbank_q] ? FETCH : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wbank_q     <= 1'b0;
         rbank_q     <= 1'b0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         full_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wbank_q     <= wbank_d;
         rbank_q     <= rbank_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_fc_vector_stream_tx.sv
// Directed bench for fc_vector_stream_tx with hand-computed expected beats.
module tb_fc_vector_stream_tx;
   localparam int W = 16;
   localparam int N = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          output_valid;
   logic          output_ready;
   logic [W-1:0]  output_data;
   logic          output_last;
   logic [1:0]    vec_pending;

   int            n_chk  = 0;
   int            n_pass = 0;
   logic [W-1:0]  vbuf [N];

   always #5 clk = ~clk;

   fc_vector_stream_tx #(.WIDTH(W), .N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data),
      .output_last  (output_last),
      .vec_pending  (vec_pending)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {valid, last, data} compared as one value
   task automatic beat(input string tag, input logic [W-1:0] d, input logic last);
      chk(tag, 32'({output_valid, output_last, output_data}), 32'({1'b1, last, d}));
   endtask

   task automatic fill_seq(input logic [W-1:0] base);
      for (int i = 0; i < N; i++) vbuf[i] = base + W'(i);
   endtask

   task automatic write_vec(input string tag);
      for (int i = 0; i < N; i++) begin
         chk({tag, "_in_rdy"}, 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = vbuf[i];
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input string tag);
      for (int i = 0; i < N; i++) begin
         beat(tag, vbuf[i], i == N - 1);
         step();
      end
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (output_valid) break;
         step();
      end
      chk({tag, "_wait_vld"}, 32'(output_valid), 32'd1);
   endtask

   task automatic put_word(input logic [W-1:0] d);
      logic rdy;
      rdy      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 60; i++) begin
         rdy = in_ready;
         step();
         if (rdy) break;
      end
      chk("put_acc", 32'(rdy), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      output_ready = 1'b0;
      step();
      step();
      chk("rst_out", 32'({output_valid, output_last, output_data}), 32'd0);
      chk("rst_in_rdy", 32'(in_ready), 32'd1);
      chk("rst_pend", 32'(vec_pending), 32'd0);
      reset = 1'b0;
      step();

      // single vector, fc always ready: latency and last marker
      output_ready = 1'b1;
      fill_seq(16'd1);
      write_vec("t1");
      chk("t1_pend", 32'(vec_pending), 32'd1);
      chk("t1_lat0", 32'(output_valid), 32'd0);
      step();
      chk("t1_lat1", 32'(output_valid), 32'd0);
      step();
      send_vec("t1_beat");
      chk("t1_end_vld", 32'(output_valid), 32'd0);
      chk("t1_end_pend", 32'(vec_pending), 32'd0);

      // backpressure pattern 1,0,0 repeating
      output_ready = 1'b0;
      fill_seq(16'd1);
      write_vec("t2");
      wait_valid("t2");
      begin
         int k;
         k = 0;
         for (int c = 0; c < 40 && k < N; c++) begin
            beat("t2_hold", W'(k + 1), k == N - 1);
            output_ready = ((c % 3) == 0);
            step();
            if (output_ready) k++;
         end
         output_ready = 1'b0;
         chk("t2_count", 32'(k), 32'(N));
         chk("t2_end_vld", 32'(output_valid), 32'd0);
      end

      // three vectors against a stalled fc: both banks fill, third is held off
      for (int i = 0; i < 2 * N; i++) begin
         chk("t3_in_rdy", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = (i < N) ? W'(16'h11 + i) : W'(16'h21 + i - N);
         step();
      end
      chk("t3_full_rdy", 32'(in_ready), 32'd0);
      chk("t3_full_pend", 32'(vec_pending), 32'd2);
      in_data = 16'h31;
      step();
      step();
      step();
      chk("t3_stall_rdy", 32'(in_ready), 32'd0);
      chk("t3_stall_pend", 32'(vec_pending), 32'd2);
      fork
         begin
            for (int i = 0; i < N; i++) put_word(W'(16'h31 + i));
            in_valid = 1'b0;
         end
         begin
            output_ready = 1'b1;
            for (int b = 0; b < N; b++) begin
               beat("t3_v1", W'(16'h11 + b), b == N - 1);
               step();
            end
            chk("t3_bubble", 32'(output_valid), 32'd0);
            step();
            for (int b = 0; b < N; b++) begin
               beat("t3_v2", W'(16'h21 + b), b == N - 1);
               step();
            end
            wait_valid("t3_v3");
            for (int b = 0; b < N; b++) begin
               beat("t3_v3", W'(16'h31 + b), b == N - 1);
               step();
            end
         end
      join
      chk("t3_end_pend", 32'(vec_pending), 32'd0);

      // vector B completes on the edge vector A sends its last word
      output_ready = 1'b0;
      fill_seq(16'h51);
      write_vec("t4a");
      for (int i = 0; i < N - 1; i++) begin
         chk("t4b_in_rdy", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = W'(16'h41 + i);
         step();
      end
      in_valid = 1'b0;
      chk("t4_pre_pend", 32'(vec_pending), 32'd1);
      beat("t4_a_held", 16'h51, 1'b0);
      output_ready = 1'b1;
      for (int b = 0; b < N; b++) begin
         beat("t4_a", W'(16'h51 + b), b == N - 1);
         if (b == N - 1) begin
            in_valid = 1'b1;
            in_data  = 16'h48;
         end
         step();
      end
      in_valid = 1'b0;
      chk("t4_simul_pend", 32'(vec_pending), 32'd1);
      chk("t4_bubble", 32'(output_valid), 32'd0);
      step();
      for (int b = 0; b < N; b++) begin
         beat("t4_b", W'(16'h41 + b), b == N - 1);
         step();
      end
      chk("t4_end_vld", 32'(output_valid), 32'd0);
      chk("t4_end_pend", 32'(vec_pending), 32'd0);

      // extreme and alternating bit patterns pass through untouched
      vbuf[0] = 16'h7FFF; vbuf[1] = 16'h8000; vbuf[2] = 16'hAAAA; vbuf[3] = 16'h5555;
      vbuf[4] = 16'h0000; vbuf[5] = 16'hFFFF; vbuf[6] = 16'h0001; vbuf[7] = 16'hFFFE;
      write_vec("t6");
      wait_valid("t6");
      send_vec("t6_beat");
      chk("t6_end_vld", 32'(output_valid), 32'd0);

      // reset on beat 4 while a second vector is part-written
      fill_seq(16'h61);
      write_vec("t5");
      wait_valid("t5");
      for (int b = 0; b < 3; b++) begin
         in_valid = 1'b1;
         in_data  = W'(16'hEE00 + b);
         beat("t5_pre", vbuf[b], 1'b0);
         step();
      end
      beat("t5_beat4", vbuf[3], 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      chk("t5_rst_out", 32'({output_valid, output_last, output_data}), 32'd0);
      chk("t5_rst_in_rdy", 32'(in_ready), 32'd1);
      chk("t5_rst_pend", 32'(vec_pending), 32'd0);
      reset = 1'b0;
      step();
      fill_seq(16'd9);
      write_vec("t5n");
      wait_valid("t5n");
      send_vec("t5n_beat");
      chk("t5_end_vld", 32'(output_valid), 32'd0);
      chk("t5_end_pend", 32'(vec_pending), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
